result_merge_fifo: RTL and testbench

//  Downstream of the two-lane shared-resource stage. Buffers each lane's result

---
 rtl/result_merge_fifo.sv | 170 +++++++++++++++++
 tb/tb_result_merge_fifo.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_merge_fifo.sv
// result_merge_fifo
//   Buffers the result beats of two lanes in per-lane FIFOs and merges them
//   round-robin onto a single registered valid/ready output stream. Each lane
//   can be flushed independently, and beats that arrive at a full FIFO are
//   dropped and flagged.
//
// Optional feature: define RESULT_MERGE_STATS_EN to add the saturating per-lane
// drop counters drop_cnt_1/drop_cnt_2. When it is not defined those ports do not
// exist and all other behaviour is unchanged.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   in_valid_N/in_data_N   lane N beat (one beat per high cycle)
//   in_flush_N             clear lane N FIFO and kill a pending lane N output beat
//   in_ready_N             lane N FIFO not full (0 while reset is high)
//   out_valid/out_data     registered output beat
//   out_src                0 = lane 1, 1 = lane 2
//   out_ready              consumer accepts when out_valid & out_ready
//   overflow_N             sticky: a lane N beat was dropped
//   drop_cnt_N             dropped-beat counters (RESULT_MERGE_STATS_EN only)
module result_merge_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_1,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              in_flush_1,
  input  logic              in_valid_2,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_flush_2,
  output logic              in_ready_1,
  output logic              in_ready_2,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic              overflow_1,
  output logic              overflow_2
`ifdef RESULT_MERGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  drop_cnt_1,
  output logic [CNT_W-1:0]  drop_cnt_2
`endif
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W == 0) begin : g_param_check
    $error("result_merge_fifo: DEPTH must be a power of 2 >= 2 and CNT_W nonzero");
  end

  // Lane index 0 is lane 1, index 1 is lane 2.
  logic [1:0]        in_valid, in_flush;
  logic [DATA_W-1:0] in_data   [2];
  logic [DATA_W-1:0] head_data [2];
  logic [1:0]        empty, full, push, drop, elig;

  logic [DATA_W-1:0] mem_q      [2][DEPTH];
  logic [PtrW-1:0]   wr_ptr_q   [2];
  logic [PtrW-1:0]   rd_ptr_q   [2];
  logic [1:0]        overflow_q;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_src_q;
  logic              last_q;     // lane served by the most recent load (1 = lane 2)

  logic              kill, load_slot, load, sel;
  logic [1:0]        pop;

  always_comb begin
    in_valid   = {in_valid_2, in_valid_1};
    in_flush   = {in_flush_2, in_flush_1};
    in_data[0] = in_data_1;
    in_data[1] = in_data_2;
    for (int i = 0; i < 2; i++) begin
      empty[i]     = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]      = (wr_ptr_q[i][PtrW-1] != rd_ptr_q[i][PtrW-1]) &&
                     (wr_ptr_q[i][AddrW-1:0] == rd_ptr_q[i][AddrW-1:0]);
      // Push decision uses the full flag at the start of the cycle, so a
      // same-cycle pop never makes room for a push.
      push[i]      = in_valid[i] & ~in_flush[i] & ~full[i];
      drop[i]      = in_valid[i] & ~in_flush[i] & full[i];
      elig[i]      = ~empty[i] & ~in_flush[i];
      head_data[i] = mem_q[i][rd_ptr_q[i][AddrW-1:0]];
    end

    // A flush of the lane whose beat sits in the output register discards it,
    // and the register stays empty for that cycle regardless of out_ready.
    kill      = out_valid_q & in_flush[out_src_q];
    load_slot = (~out_valid_q | out_ready) & ~kill;
    sel       = (elig == 2'b11) ? ~last_q : elig[1];
    load      = load_slot & (|elig);
    pop       = 2'b00;
    if (load) pop[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      overflow_q  <= 2'b00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (in_flush[i]) begin
          wr_ptr_q[i] <= '0;
          rd_ptr_q[i] <= '0;
        end else begin
          if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
          if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        end
        if (drop[i]) overflow_q[i] <= 1'b1;
      end

      if (kill) begin
        out_valid_q <= 1'b0;
      end else if (load_slot) begin
        out_valid_q <= |elig;
      end
      if (load) begin
        out_data_q <= head_data[sel];
        out_src_q  <= sel;
        last_q     <= sel;
      end
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i][AddrW-1:0]] <= in_data[i];
    end
  end

`ifdef RESULT_MERGE_STATS_EN
  logic [CNT_W-1:0] drop_cnt_q [2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        drop_cnt_q[i] <= '0;
      end else if (drop[i] && (drop_cnt_q[i] != {CNT_W{1'b1}})) begin
        drop_cnt_q[i] <= drop_cnt_q[i] + 1'b1;
      end
    end
  end

  assign drop_cnt_1 = drop_cnt_q[0];
  assign drop_cnt_2 = drop_cnt_q[1];
`endif

  assign in_ready_1 = ~reset & ~full[0];
  assign in_ready_2 = ~reset & ~full[1];
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign overflow_1 = overflow_q[0];
  assign overflow_2 = overflow_q[1];

endmodule

// File: tb/tb_result_merge_fifo.sv
// tb_result_merge_fifo
//   Self-checking bench for result_merge_fifo: a table of directed vectors,
//   hand-written multi-cycle sequences (overflow, flush, reset mid-traffic), and
//   randomized traffic compared every cycle against a queue-based reference model.
module tb_result_merge_fifo;

  localparam int unsigned DataW  = 32;
  localparam int unsigned Depth  = 4;
  localparam int unsigned CntW   = 16;
  localparam int          CntMax = (1 << CntW) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid_1 = 1'b0, in_flush_1 = 1'b0;
  logic             in_valid_2 = 1'b0, in_flush_2 = 1'b0;
  logic [DataW-1:0] in_data_1 = '0, in_data_2 = '0;
  logic             out_ready = 1'b0;
  logic             in_ready_1, in_ready_2, out_valid, out_src, overflow_1, overflow_2;
  logic [DataW-1:0] out_data;
`ifdef RESULT_MERGE_STATS_EN
  logic [CntW-1:0]  drop_cnt_1, drop_cnt_2;
`endif

  result_merge_fifo #(
    .DATA_W (DataW),
    .DEPTH  (Depth),
    .CNT_W  (CntW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid_1 (in_valid_1),
    .in_data_1  (in_data_1),
    .in_flush_1 (in_flush_1),
    .in_valid_2 (in_valid_2),
    .in_data_2  (in_data_2),
    .in_flush_2 (in_flush_2),
    .in_ready_1 (in_ready_1),
    .in_ready_2 (in_ready_2),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .overflow_1 (overflow_1),
    .overflow_2 (overflow_2)
`ifdef RESULT_MERGE_STATS_EN
    ,
    .drop_cnt_1 (drop_cnt_1),
    .drop_cnt_2 (drop_cnt_2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        v1;
    logic [31:0] d1;
    logic        f1;
    logic        v2;
    logic [31:0] d2;
    logic        f2;
    logic        ordy;
  } in_t;

  typedef struct packed {
    in_t         i;
    logic        ck;   // compare this row
    logic        ov;   // expected out_valid
    logic [31:0] od;   // expected out_data
    logic        os;   // expected out_src
    logic        cd;   // compare data/src even when out_valid is expected low
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  in_t  cur;
  vec_t tbl[$];

  // Reference model: one queue per lane plus the output-register contents.
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  bit          m_valid, m_src, m_last, m_ovf1, m_ovf2, synced;
  logic [31:0] m_data;
  int          m_cnt1, m_cnt2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input in_t s);
    bit full1, full2, e1, e2, kill, slot;
    if (s.rst) begin
      q1.delete();
      q2.delete();
      m_valid = 0; m_data = '0; m_src = 0; m_last = 1;
      m_ovf1 = 0; m_ovf2 = 0; m_cnt1 = 0; m_cnt2 = 0;
      synced = 1;
      return;
    end
    full1 = (q1.size() == Depth);
    full2 = (q2.size() == Depth);
    e1    = (q1.size() != 0) && !s.f1;
    e2    = (q2.size() != 0) && !s.f2;
    kill  = m_valid && (m_src ? s.f2 : s.f1);
    slot  = (!m_valid || s.ordy) && !kill;
    if (kill) begin
      m_valid = 0;
    end else if (slot) begin
      if (e1 && (!e2 || m_last)) begin
        m_data = q1.pop_front(); m_src = 0; m_last = 0; m_valid = 1;
      end else if (e2) begin
        m_data = q2.pop_front(); m_src = 1; m_last = 1; m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    if (s.f1) q1.delete();
    else if (s.v1) begin
      if (full1) begin
        m_ovf1 = 1;
        if (m_cnt1 < CntMax) m_cnt1++;
      end else q1.push_back(s.d1);
    end
    if (s.f2) q2.delete();
    else if (s.v2) begin
      if (full2) begin
        m_ovf2 = 1;
        if (m_cnt2 < CntMax) m_cnt2++;
      end else q2.push_back(s.d2);
    end
  endtask

  task automatic model_check();
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_src", out_src, m_src);
    end
    chk("in_ready_1", in_ready_1, !cur.rst && (q1.size() < Depth));
    chk("in_ready_2", in_ready_2, !cur.rst && (q2.size() < Depth));
    chk("overflow_1", overflow_1, m_ovf1);
    chk("overflow_2", overflow_2, m_ovf2);
`ifdef RESULT_MERGE_STATS_EN
    chk("drop_cnt_1", drop_cnt_1, m_cnt1);
    chk("drop_cnt_2", drop_cnt_2, m_cnt2);
`endif
  endtask

  // Apply inputs away from the active edge, then compare against the model.
  task automatic drive(input in_t s);
    @(negedge clk);
    cur        = s;
    reset      = s.rst;
    in_valid_1 = s.v1; in_data_1 = s.d1; in_flush_1 = s.f1;
    in_valid_2 = s.v2; in_data_2 = s.d2; in_flush_2 = s.f2;
    out_ready  = s.ordy;
    #1;
    if (synced) model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(cur);
  endtask

  function automatic in_t idle(input logic ordy);
    in_t s;
    s      = '0;
    s.ordy = ordy;
    return s;
  endfunction

  function automatic vec_t mk(input logic rst, input logic v1, input logic [31:0] d1,
                              input logic v2, input logic [31:0] d2, input logic ck,
                              input logic ov, input logic [31:0] od, input logic os,
                              input logic cd);
    vec_t v;
    v        = '0;
    v.i.rst  = rst;
    v.i.v1   = v1;
    v.i.d1   = d1;
    v.i.v2   = v2;
    v.i.d2   = d2;
    v.i.ordy = 1'b1;
    v.ck     = ck;
    v.ov     = ov;
    v.od     = od;
    v.os     = os;
    v.cd     = cd;
    return v;
  endfunction

  initial begin
    in_t s;
    int  rdy_pct;

    // Reset, then idle: nothing valid, both lanes ready, data/src cleared.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    // Lane 1 stream A0..A3 with out_ready held high.
    tbl.push_back(mk(0, 1, 32'hA0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hA1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hA2, 0, 0, 1, 1, 32'hA0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hA3, 0, 0, 1, 1, 32'hA1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'hA2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'hA3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Fresh reset, then both lanes push every cycle: round-robin interleave.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 32'h10, 1, 32'h20, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h11, 1, 32'h21, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h10, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h20, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h11, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h21, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      if (tbl[k].ck) begin
        chk($sformatf("tbl%0d_out_valid", k), out_valid, tbl[k].ov);
        chk($sformatf("tbl%0d_in_ready_1", k), in_ready_1, 1'b1);
        chk($sformatf("tbl%0d_in_ready_2", k), in_ready_2, 1'b1);
        if (tbl[k].ov || tbl[k].cd) begin
          chk($sformatf("tbl%0d_out_data", k), out_data, tbl[k].od);
          chk($sformatf("tbl%0d_out_src", k), out_src, tbl[k].os);
        end
      end
      tick();
    end

    // Overflow: lane 2 pushes 6 beats with the output stalled.
    s = idle(1'b1); s.rst = 1'b1;
    drive(s);
    chk("rst_in_ready_1", in_ready_1, 1'b0);
    chk("rst_in_ready_2", in_ready_2, 1'b0);
    tick();
    for (int k = 0; k < 6; k++) begin
      s = idle(1'b0); s.v2 = 1'b1; s.d2 = 32'hB0 + k;
      drive(s);
      chk($sformatf("ovf_in_ready_2_beat%0d", k), in_ready_2, (k < 5) ? 1'b1 : 1'b0);
      tick();
    end
    drive(idle(1'b0));
    chk("ovf_overflow_2", overflow_2, 1'b1);
    chk("ovf_overflow_1", overflow_1, 1'b0);
    chk("ovf_in_ready_2_full", in_ready_2, 1'b0);
    chk("ovf_held_data", out_data, 32'hB0);
    chk("ovf_held_src", out_src, 1'b1);
`ifdef RESULT_MERGE_STATS_EN
    chk("ovf_drop_cnt_2", drop_cnt_2, 32'd1);
`endif
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(idle(1'b1));
      chk($sformatf("drain%0d_valid", k), out_valid, (k < 5) ? 1'b1 : 1'b0);
      if (k < 5) chk($sformatf("drain%0d_data", k), out_data, 32'hB0 + k);
      tick();
    end
    s = idle(1'b1); s.f2 = 1'b1;
    drive(s);
    tick();
    drive(idle(1'b1));
    chk("flush_keeps_overflow_2", overflow_2, 1'b1);
    tick();

    // Flush lane 1 while its head sits in the output register.
    s = idle(1'b1); s.rst = 1'b1;
    drive(s); tick();
    for (int k = 0; k < 4; k++) begin
      s = idle(1'b0); s.v1 = 1'b1; s.d1 = 32'hC0 + k;
      if (k == 0) begin s.v2 = 1'b1; s.d2 = 32'hD0; end
      drive(s); tick();
    end
    s = idle(1'b1); s.f1 = 1'b1;
    drive(s);
    chk("fl_pre_valid", out_valid, 1'b1);
    chk("fl_pre_data", out_data, 32'hC0);
    chk("fl_pre_src", out_src, 1'b0);
    tick();
    drive(idle(1'b0));
    chk("fl_killed_valid", out_valid, 1'b0);
    chk("fl_lane1_ready", in_ready_1, 1'b1);
    tick();
    drive(idle(1'b1));
    chk("fl_lane2_valid", out_valid, 1'b1);
    chk("fl_lane2_data", out_data, 32'hD0);
    chk("fl_lane2_src", out_src, 1'b1);
    tick();
    drive(idle(1'b1));
    chk("fl_lane1_empty", out_valid, 1'b0);
    tick();

    // Reset in the middle of traffic with both FIFOs partially filled.
    for (int k = 0; k < 3; k++) begin
      s = idle(1'b0);
      s.v1 = 1'b1; s.d1 = 32'hE0 + k;
      s.v2 = 1'b1; s.d2 = 32'hF0 + k;
      drive(s); tick();
    end
    s = idle(1'b1); s.rst = 1'b1; s.v1 = 1'b1; s.d1 = 32'hEE;
    drive(s); tick();
    for (int k = 0; k < 3; k++) begin
      drive(idle(1'b1));
      chk($sformatf("mrst%0d_valid", k), out_valid, 1'b0);
      chk($sformatf("mrst%0d_ready_1", k), in_ready_1, 1'b1);
      chk($sformatf("mrst%0d_ready_2", k), in_ready_2, 1'b1);
      chk($sformatf("mrst%0d_ovf", k), {overflow_2, overflow_1}, 2'b00);
      tick();
    end

    // Randomized traffic with phases of varying back-pressure.
    rdy_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) rdy_pct = $urandom_range(0, 100);
      s      = '0;
      s.rst  = ($urandom_range(0, 399) == 0);
      s.v1   = ($urandom_range(0, 99) < 55);
      s.d1   = $urandom;
      s.f1   = ($urandom_range(0, 29) == 0);
      s.v2   = ($urandom_range(0, 99) < 55);
      s.d2   = $urandom;
      s.f2   = ($urandom_range(0, 29) == 0);
      s.ordy = ($urandom_range(0, 99) < rdy_pct);
      drive(s);
      tick();
    end
    drive(idle(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
